// File: rtl/boreal_adc_frame_seq_if.sv
// Output sample stream of the ADC frame sequencer.
//   s_valid : head entry valid (producer -> consumer)
//   s_ready : consumer accepts head when s_valid & s_ready
//   s_ch    : channel index of head
//   s_data  : signed sample of head
// master = sequencer side, slave = consumer side.
interface boreal_adc_frame_seq_if #(
  parameter int CH_W  = 3,
  parameter int OUT_W = 16
);
  logic             s_valid;
  logic             s_ready;
  logic [CH_W-1:0]  s_ch;
  logic [OUT_W-1:0] s_data;

  modport master (output s_valid, output s_ch, output s_data, input s_ready);
  modport slave  (input s_valid, input s_ch, input s_data, output s_ready);
endinterface

// File: rtl/boreal_adc_frame_seq.sv
// ADS1299-family frame sequencer. On a synchronised DRDY falling edge it reads
// one SPI frame (status word + N_CH channel words, MSB first, mode 1) and
// pushes each channel word, truncated to OUT_W and tagged with its index,
// into a first-word-fall-through output FIFO.
// Ports:
//   clk, rst          system clock, async active-high reset
//   enable            allow new frames on DRDY
//   clr_flags         pulse: clear sticky overrun/overflow
//   drdy_n, miso      ADC data-ready (async) and serial data
//   sclk, cs_n        SPI clock (idle low) and chip select
//   s                 output sample stream (master modport)
//   status            status word of the last frame
//   frame_cnt         completed frames, wrapping
//   busy              frame in progress
//   overrun/overflow  sticky: DRDY while busy / sample dropped on full FIFO
//
// state | meaning
// IDLE  | waiting for DRDY event with enable=1
// SETUP | cs_n low, SCLK_DIV cycles before first sclk edge
// SHIFT | clocking out all frame bits
// HOLD  | cs_n high, SCLK_DIV cycles, then frame counted
module boreal_adc_frame_seq #(
  parameter int N_CH       = 8,
  parameter int SAMPLE_W   = 24,
  parameter int STATUS_W   = 24,
  parameter int OUT_W      = 16,
  parameter int SCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     clr_flags,
  input  logic                     drdy_n,
  input  logic                     miso,
  output logic                     sclk,
  output logic                     cs_n,
  boreal_adc_frame_seq_if.master   s,
  output logic [STATUS_W-1:0]      status,
  output logic [15:0]              frame_cnt,
  output logic                     busy,
  output logic                     overrun,
  output logic                     overflow
);
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TOTAL_BITS = STATUS_W + N_CH * SAMPLE_W;
  localparam int BIT_W      = $clog2(TOTAL_BITS);
  localparam int DIV_W      = $clog2(SCLK_DIV);
  localparam int SH_W       = (STATUS_W > SAMPLE_W) ? STATUS_W : SAMPLE_W;
  localparam int WL_W       = $clog2(SH_W);
  localparam int AW         = $clog2(FIFO_DEPTH);

  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BITS_LAST   = BIT_W'(TOTAL_BITS - 1);
  localparam logic [WL_W-1:0]  STATUS_LAST = WL_W'(STATUS_W - 1);
  localparam logic [WL_W-1:0]  SAMPLE_LAST = WL_W'(SAMPLE_W - 1);
  localparam logic [AW:0]      FIFO_FULL   = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  state_t state_q, state_d;

  // DRDY synchroniser plus one delayed copy for edge detection
  logic drdy_s1, drdy_s2, drdy_s3, drdy_event;

  logic [DIV_W-1:0]  div_cnt;
  logic              low_half;
  logic [BIT_W-1:0]  bits_left;
  logic [WL_W-1:0]   word_left;
  logic              in_status;
  logic [SH_W-1:0]   shreg;
  logic              word_done, done_status;
  logic [CH_W-1:0]   ch_idx;
  logic              push_v;
  logic [CH_W-1:0]   push_ch;
  logic [OUT_W-1:0]  push_data;
  logic              phase_end, bit_fall, bit_end;

  logic [CH_W-1:0]   mem_ch   [FIFO_DEPTH];
  logic [OUT_W-1:0]  mem_data [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              full, pop, do_push, drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drdy_s1 <= 1'b1;
      drdy_s2 <= 1'b1;
      drdy_s3 <= 1'b1;
    end else begin
      drdy_s1 <= drdy_n;
      drdy_s2 <= drdy_s1;
      drdy_s3 <= drdy_s2;
    end
  end

  assign drdy_event = drdy_s3 & ~drdy_s2;

  assign phase_end = (div_cnt == '0);
  assign bit_fall  = (state_q == SHIFT) && phase_end && !low_half;
  assign bit_end   = (state_q == SHIFT) && phase_end && low_half;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (drdy_event && enable)          state_d = SETUP;
      SETUP:   if (phase_end)                     state_d = SHIFT;
      SHIFT:   if (bit_end && bits_left == '0)    state_d = HOLD;
      HOLD:    if (phase_end)                     state_d = IDLE;
      default:                                    state_d = IDLE;
    endcase
  end

  assign sclk = (state_q == SHIFT) && !low_half;
  assign cs_n = !((state_q == SETUP) || (state_q == SHIFT));
  assign busy = (state_q != IDLE);

  // Timing: div_cnt times each phase; low_half selects the sclk-low half-bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt   <= DIV_LAST;
      low_half  <= 1'b0;
      bits_left <= BITS_LAST;
      frame_cnt <= 16'h0000;
    end else begin
      if (state_d != state_q || phase_end) div_cnt <= DIV_LAST;
      else                                 div_cnt <= div_cnt - DIV_W'(1);

      if (state_q != SHIFT)  low_half <= 1'b0;
      else if (phase_end)    low_half <= ~low_half;

      if (state_q == SETUP)                   bits_left <= BITS_LAST;
      else if (bit_end && bits_left != '0)    bits_left <= bits_left - BIT_W'(1);

      if (state_q == HOLD && phase_end) frame_cnt <= frame_cnt + 16'h0001;
    end
  end

  // Shift and word framing. A completed word is flagged on the sampling edge,
  // then captured into status or the push stage on the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg       <= '0;
      word_left   <= STATUS_LAST;
      in_status   <= 1'b1;
      word_done   <= 1'b0;
      done_status <= 1'b0;
      ch_idx      <= '0;
      push_v      <= 1'b0;
      push_ch     <= '0;
      push_data   <= '0;
      status      <= '0;
    end else begin
      word_done <= 1'b0;
      push_v    <= 1'b0;
      if (state_q == SETUP) begin
        word_left <= STATUS_LAST;
        in_status <= 1'b1;
        ch_idx    <= '0;
      end else if (bit_fall) begin
        shreg <= {shreg[SH_W-2:0], miso};
        if (word_left == '0) begin
          word_left   <= SAMPLE_LAST;
          word_done   <= 1'b1;
          done_status <= in_status;
          in_status   <= 1'b0;
        end else begin
          word_left <= word_left - WL_W'(1);
        end
      end
      if (word_done) begin
        if (done_status) begin
          status <= shreg[STATUS_W-1:0];
        end else begin
          push_v    <= 1'b1;
          push_ch   <= ch_idx;
          push_data <= shreg[SAMPLE_W-1 -: OUT_W];
          ch_idx    <= ch_idx + CH_W'(1);
        end
      end
    end
  end

  assign full    = (count == FIFO_FULL);
  assign pop     = (count != '0) && s.s_ready;
  assign do_push = push_v && (!full || pop);
  assign drop    = push_v && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_ch[i]   <= '0;
        mem_data[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_ch[wr_ptr]   <= push_ch;
        mem_data[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign s.s_valid = (count != '0);
  assign s.s_ch    = mem_ch[rd_ptr];
  assign s.s_data  = mem_data[rd_ptr];

  // Sticky flags: a set in the same cycle as clr_flags wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (drdy_event && busy) overrun <= 1'b1;
      else if (clr_flags)     overrun <= 1'b0;
      if (drop)               overflow <= 1'b1;
      else if (clr_flags)     overflow <= 1'b0;
    end
  end
endmodule
